// File: rtl/periph_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : periph_mmio_pkg
// Purpose  : Shared definitions for the MMIO peripheral responder: register
//            word indices (addr[4:2]), CTRL/STATUS bit positions and the
//            byte-lane to bit-mask helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package periph_mmio_pkg;

   // Word index inside the 32-byte window, i.e. addr[4:2].
   typedef logic [2:0] reg_idx_t;

   localparam reg_idx_t OFF_GPIO_OUT = 3'd0;  // 0x00
   localparam reg_idx_t OFF_GPIO_IN  = 3'd1;  // 0x04
   localparam reg_idx_t OFF_MTIME_LO = 3'd2;  // 0x08
   localparam reg_idx_t OFF_MTIME_HI = 3'd3;  // 0x0C
   localparam reg_idx_t OFF_CMP_LO   = 3'd4;  // 0x10
   localparam reg_idx_t OFF_CMP_HI   = 3'd5;  // 0x14
   localparam reg_idx_t OFF_CTRL     = 3'd6;  // 0x18
   localparam reg_idx_t OFF_STATUS   = 3'd7;  // 0x1C

   localparam int CTRL_TEN    = 0;
   localparam int CTRL_IEN    = 1;
   localparam int STATUS_PEND = 0;

   // Expand byte enables to a 32-bit mask: bit i of be covers data[8i+7:8i].
   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) begin
         m[8*i +: 8] = {8{be[i]}};
      end
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/periph_timer64.sv
`default_nettype none
// ============================================================================
// Module   : periph_timer64
// Purpose  : 64-bit machine timer with prescaler, 64-bit compare, CTRL
//            (TEN/IEN) and sticky PEND status driving a level interrupt.
// Ports    : clock, reset          - clock, async active-high reset
//            wr_i                  - qualified write strobe (in window, be!=0)
//            wr_sel_i              - register word index of the write
//            wr_data_i, wr_mask_i  - write data and byte-lane bit mask
//            mtime_o, cmp_o        - current counter and compare values
//            ctrl_o                - {IEN, TEN}
//            pend_o, irq_o         - pending flag and PEND & IEN
// Revision : 1.0 - initial release
// ============================================================================
module periph_timer64
   import periph_mmio_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wr_i,
   input  reg_idx_t    wr_sel_i,
   input  logic [31:0] wr_data_i,
   input  logic [31:0] wr_mask_i,
   output logic [63:0] mtime_o,
   output logic [63:0] cmp_o,
   output logic [1:0]  ctrl_o,
   output logic        pend_o,
   output logic        irq_o
);

   localparam int          PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [63:0]   mtime_q, mtime_d;
   logic [63:0]   cmp_q,   cmp_d;
   logic          ten_q,   ten_d;
   logic          ien_q,   ien_d;
   logic          pend_q,  pend_d;

   logic tick;
   logic set_pend;
   logic clr_pend;

   function automatic logic [31:0] merge(input logic [31:0] old_v,
                                         input logic [31:0] new_v,
                                         input logic [31:0] m);
      return (old_v & ~m) | (new_v & m);
   endfunction

   assign tick     = ten_q && (presc_q == PRE_MAX);
   assign set_pend = ten_q && (mtime_q >= cmp_q);

   always_comb begin
      presc_d  = presc_q;
      mtime_d  = mtime_q;
      cmp_d    = cmp_q;
      ten_d    = ten_q;
      ien_d    = ien_q;
      clr_pend = 1'b0;

      // Prescaler holds its count while the timer is disabled.
      if (ten_q) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
      end
      if (tick) begin
         mtime_d = mtime_q + 64'd1;
      end

      if (wr_i) begin
         case (wr_sel_i)
            // An mtime write overrides the increment entirely: unwritten
            // lanes keep their pre-increment value.
            OFF_MTIME_LO: mtime_d = {mtime_q[63:32],
                                     merge(mtime_q[31:0], wr_data_i, wr_mask_i)};
            OFF_MTIME_HI: mtime_d = {merge(mtime_q[63:32], wr_data_i, wr_mask_i),
                                     mtime_q[31:0]};
            OFF_CMP_LO:   cmp_d   = {cmp_q[63:32],
                                     merge(cmp_q[31:0], wr_data_i, wr_mask_i)};
            OFF_CMP_HI:   cmp_d   = {merge(cmp_q[63:32], wr_data_i, wr_mask_i),
                                     cmp_q[31:0]};
            OFF_CTRL: begin
               if (wr_mask_i[CTRL_TEN]) ten_d = wr_data_i[CTRL_TEN];
               if (wr_mask_i[CTRL_IEN]) ien_d = wr_data_i[CTRL_IEN];
            end
            OFF_STATUS:   clr_pend = wr_mask_i[STATUS_PEND] & wr_data_i[STATUS_PEND];
            default: ;
         endcase
      end

      // Set has priority over a same-cycle write-1-to-clear.
      pend_d = set_pend | (pend_q & ~clr_pend);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
         mtime_q <= '0;
         cmp_q   <= '1;
         ten_q   <= 1'b0;
         ien_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         mtime_q <= mtime_d;
         cmp_q   <= cmp_d;
         ten_q   <= ten_d;
         ien_q   <= ien_d;
         pend_q  <= pend_d;
      end
   end

   assign mtime_o = mtime_q;
   assign cmp_o   = cmp_q;
   assign ctrl_o  = {ien_q, ten_q};
   assign pend_o  = pend_q;
   assign irq_o   = pend_q & ien_q;

endmodule
`default_nettype wire

// File: rtl/periph_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : periph_mmio_responder
// Purpose  : Memory-mapped peripheral on the data-memory request/response
//            bus. Holds address decode, GPIO out/in and the one-cycle
//            response register; the timer lives in periph_timer64.
// Ports    : clock, reset                 - clock, async active-high reset
//            io_req_*                      - request (valid, addr, data, be, wr)
//            io_rsp_valid, io_rsp_bits_*   - registered response, 1-cycle latency
//            io_gpio_in / io_gpio_out      - async GPIO inputs / output register
//            io_timer_irq                  - level timer interrupt
// Revision : 1.0 - initial release
// ============================================================================
module periph_mmio_responder
   import periph_mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int          GPIO_W    = 32,
   parameter int          PRESCALE  = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_req_valid,
   input  logic [31:0]       io_req_bits_addrRequest,
   input  logic [31:0]       io_req_bits_dataRequest,
   input  logic [3:0]        io_req_bits_activeByteLane,
   input  logic              io_req_bits_isWrite,
   output logic              io_rsp_valid,
   output logic [31:0]       io_rsp_bits_dataResponse,
   input  logic [GPIO_W-1:0] io_gpio_in,
   output logic [GPIO_W-1:0] io_gpio_out,
   output logic              io_timer_irq
);

   logic              hit;
   reg_idx_t          idx;
   logic [31:0]       wmask;
   logic              wr;
   logic [31:0]       rdata;
   logic              w_unused_addr;

   logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
   logic [GPIO_W-1:0] sync1_q;
   logic [GPIO_W-1:0] sync2_q;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_data_q,  rsp_data_d;

   logic [63:0]       mtime;
   logic [63:0]       cmp;
   logic [1:0]        ctrl;
   logic              pend;

   assign hit   = (io_req_bits_addrRequest[31:5] == BASE_ADDR[31:5]);
   assign idx   = io_req_bits_addrRequest[4:2];
   assign wmask = lane_mask(io_req_bits_activeByteLane);
   // Lane 0000 writes still get a response but touch no state.
   assign wr    = io_req_valid & io_req_bits_isWrite & hit &
                  (|io_req_bits_activeByteLane);

   // Byte offset within a word is ignored.
   assign w_unused_addr = ^io_req_bits_addrRequest[1:0];

   periph_timer64 #(
      .PRESCALE (PRESCALE)
   ) u_timer (
      .clock     (clock),
      .reset     (reset),
      .wr_i      (wr),
      .wr_sel_i  (idx),
      .wr_data_i (io_req_bits_dataRequest),
      .wr_mask_i (wmask),
      .mtime_o   (mtime),
      .cmp_o     (cmp),
      .ctrl_o    (ctrl),
      .pend_o    (pend),
      .irq_o     (io_timer_irq)
   );

   // Read mux works on current register values, i.e. before any update
   // caused by a write in the same cycle.
   always_comb begin
      rdata = '0;
      case (idx)
         OFF_GPIO_OUT: rdata[GPIO_W-1:0] = gpio_out_q;
         OFF_GPIO_IN:  rdata[GPIO_W-1:0] = sync2_q;
         OFF_MTIME_LO: rdata = mtime[31:0];
         OFF_MTIME_HI: rdata = mtime[63:32];
         OFF_CMP_LO:   rdata = cmp[31:0];
         OFF_CMP_HI:   rdata = cmp[63:32];
         OFF_CTRL:     rdata[1:0] = ctrl;
         OFF_STATUS:   rdata[STATUS_PEND] = pend;
         default:      rdata = '0;
      endcase
   end

   always_comb begin
      gpio_out_d = gpio_out_q;
      if (wr && (idx == OFF_GPIO_OUT)) begin
         gpio_out_d = (gpio_out_q & ~wmask[GPIO_W-1:0]) |
                      (io_req_bits_dataRequest[GPIO_W-1:0] & wmask[GPIO_W-1:0]);
      end

      rsp_valid_d = io_req_valid;
      rsp_data_d  = '0;
      if (io_req_valid && !io_req_bits_isWrite && hit) begin
         rsp_data_d = rdata;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         gpio_out_q  <= '0;
         sync1_q     <= '0;
         sync2_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         gpio_out_q  <= gpio_out_d;
         sync1_q     <= io_gpio_in;
         sync2_q     <= sync1_q;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign io_gpio_out              = gpio_out_q;
   assign io_rsp_valid             = rsp_valid_q;
   assign io_rsp_bits_dataResponse = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_periph_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_periph_mmio_responder
// Purpose  : Directed self-checking bench for periph_mmio_responder.
//            Requests are driven on the falling edge and responses are
//            observed on the following falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_periph_mmio_responder;

   logic        clock;
   logic        reset;
   logic        io_req_valid;
   logic [31:0] io_req_bits_addrRequest;
   logic [31:0] io_req_bits_dataRequest;
   logic [3:0]  io_req_bits_activeByteLane;
   logic        io_req_bits_isWrite;
   logic        io_rsp_valid;
   logic [31:0] io_rsp_bits_dataResponse;
   logic [31:0] io_gpio_in;
   logic [31:0] io_gpio_out;
   logic        io_timer_irq;

   int checks = 0;
   int errors = 0;

   periph_mmio_responder #(
      .BASE_ADDR (32'h4000_0000),
      .GPIO_W    (32),
      .PRESCALE  (1)
   ) dut (
      .clock                      (clock),
      .reset                      (reset),
      .io_req_valid               (io_req_valid),
      .io_req_bits_addrRequest    (io_req_bits_addrRequest),
      .io_req_bits_dataRequest    (io_req_bits_dataRequest),
      .io_req_bits_activeByteLane (io_req_bits_activeByteLane),
      .io_req_bits_isWrite        (io_req_bits_isWrite),
      .io_rsp_valid               (io_rsp_valid),
      .io_rsp_bits_dataResponse   (io_rsp_bits_dataResponse),
      .io_gpio_in                 (io_gpio_in),
      .io_gpio_out                (io_gpio_out),
      .io_timer_irq               (io_timer_irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drive one request for exactly one cycle; returns on the next falling
   // edge, where the response to this request is visible. Consecutive calls
   // give back-to-back requests.
   task automatic send(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic w);
      io_req_valid               = 1'b1;
      io_req_bits_addrRequest    = a;
      io_req_bits_dataRequest    = d;
      io_req_bits_activeByteLane = be;
      io_req_bits_isWrite        = w;
      @(negedge clock);
      io_req_valid               = 1'b0;
      io_req_bits_isWrite        = 1'b0;
      io_req_bits_activeByteLane = 4'h0;
   endtask

   task automatic test_reset;
      checks++;
      if (io_rsp_valid !== 1'b0 || io_rsp_bits_dataResponse !== 32'h0) begin
         errors++;
         $display("FAIL reset_rsp: valid=%b data=%h required valid=0 data=0",
                  io_rsp_valid, io_rsp_bits_dataResponse);
      end
      checks++;
      if (io_gpio_out !== 32'h0) begin
         errors++;
         $display("FAIL reset_gpio_out: got %h required 00000000", io_gpio_out);
      end
      checks++;
      if (io_timer_irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq: got %b required 0", io_timer_irq);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_cmp_reset;
      send(32'h4000_0010, 32'h0, 4'h0, 1'b0);
      checks++;
      if (io_rsp_valid !== 1'b1 || io_rsp_bits_dataResponse !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL cmp_lo_reset: valid=%b data=%h required valid=1 data=ffffffff",
                  io_rsp_valid, io_rsp_bits_dataResponse);
      end
      send(32'h4000_0014, 32'h0, 4'h0, 1'b0);
      checks++;
      if (io_rsp_valid !== 1'b1 || io_rsp_bits_dataResponse !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL cmp_hi_reset: valid=%b data=%h required valid=1 data=ffffffff",
                  io_rsp_valid, io_rsp_bits_dataResponse);
      end
      @(negedge clock);
      checks++;
      if (io_rsp_valid !== 1'b0 || io_rsp_bits_dataResponse !== 32'h0) begin
         errors++;
         $display("FAIL idle_rsp: valid=%b data=%h required valid=0 data=0",
                  io_rsp_valid, io_rsp_bits_dataResponse);
      end
   endtask

   task automatic test_gpio_out;
      send(32'h4000_0000, 32'hA5A5_A5A5, 4'b0010, 1'b1);
      checks++;
      if (io_rsp_valid !== 1'b1 || io_rsp_bits_dataResponse !== 32'h0) begin
         errors++;
         $display("FAIL gpio_write_rsp: valid=%b data=%h required valid=1 data=0",
                  io_rsp_valid, io_rsp_bits_dataResponse);
      end
      checks++;
      if (io_gpio_out !== 32'h0000_A500) begin
         errors++;
         $display("FAIL gpio_out_pin: got %h required 0000a500", io_gpio_out);
      end
      send(32'h4000_0000, 32'h0, 4'h0, 1'b0);
      checks++;
      if (io_rsp_valid !== 1'b1 || io_rsp_bits_dataResponse !== 32'h0000_A500) begin
         errors++;
         $display("FAIL gpio_out_read: valid=%b data=%h required valid=1 data=0000a500",
                  io_rsp_valid, io_rsp_bits_dataResponse);
      end
      // Byte offset bits are ignored.
      send(32'h4000_0003, 32'h0, 4'h0, 1'b0);
      checks++;
      if (io_rsp_bits_dataResponse !== 32'h0000_A500) begin
         errors++;
         $display("FAIL addr_low_bits: got %h required 0000a500",
                  io_rsp_bits_dataResponse);
      end
      // Lane 0000 write is a no-op but answered.
      send(32'h4000_0000, 32'hFFFF_FFFF, 4'b0000, 1'b1);
      checks++;
      if (io_rsp_valid !== 1'b1 || io_gpio_out !== 32'h0000_A500) begin
         errors++;
         $display("FAIL zero_lane_write: valid=%b gpio=%h required valid=1 gpio=0000a500",
                  io_rsp_valid, io_gpio_out);
      end
   endtask

   task automatic test_gpio_in;
      logic [31:0] exp_v [3];
      exp_v[0] = 32'h0;
      exp_v[1] = 32'h0;
      exp_v[2] = 32'h0000_1234;
      io_gpio_in = 32'h0000_1234;
      for (int i = 0; i < 3; i++) begin
         send(32'h4000_0004, 32'h0, 4'h0, 1'b0);
         checks++;
         if (io_rsp_valid !== 1'b1 || io_rsp_bits_dataResponse !== exp_v[i]) begin
            errors++;
            $display("FAIL gpio_in_sync[%0d]: valid=%b data=%h required valid=1 data=%h",
                     i, io_rsp_valid, io_rsp_bits_dataResponse, exp_v[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] addr_v [3];
      logic [31:0] exp_v  [3];
      addr_v[0] = 32'h4000_0008; exp_v[0] = 32'h1234_5678;
      addr_v[1] = 32'h4000_001C; exp_v[1] = 32'h0;
      addr_v[2] = 32'h5000_0000; exp_v[2] = 32'h0;
      send(32'h4000_0008, 32'h1234_5678, 4'hF, 1'b1);
      for (int i = 0; i < 3; i++) begin
         send(addr_v[i], 32'h0, 4'h0, 1'b0);
         checks++;
         if (io_rsp_valid !== 1'b1 || io_rsp_bits_dataResponse !== exp_v[i]) begin
            errors++;
            $display("FAIL b2b[%0d]: valid=%b data=%h required valid=1 data=%h",
                     i, io_rsp_valid, io_rsp_bits_dataResponse, exp_v[i]);
         end
      end
      // Out-of-window write must not alias onto GPIO_OUT.
      send(32'h5000_0000, 32'hFFFF_FFFF, 4'hF, 1'b1);
      checks++;
      if (io_rsp_valid !== 1'b1 || io_gpio_out !== 32'h0000_A500) begin
         errors++;
         $display("FAIL outside_write: valid=%b gpio=%h required valid=1 gpio=0000a500",
                  io_rsp_valid, io_gpio_out);
      end
   endtask

   task automatic test_timer;
      send(32'h4000_0008, 32'hFFFF_FFFE, 4'hF, 1'b1);
      send(32'h4000_000C, 32'h0000_0000, 4'hF, 1'b1);
      send(32'h4000_0014, 32'h0000_0001, 4'hF, 1'b1);
      send(32'h4000_0010, 32'h0000_0000, 4'hF, 1'b1);
      send(32'h4000_0018, 32'h0000_0003, 4'hF, 1'b1);
      // Two ticks carry mtime from 0_FFFFFFFE into 1_00000000.
      repeat (2) @(negedge clock);
      send(32'h4000_0008, 32'h0, 4'h0, 1'b0);
      checks++;
      if (io_rsp_bits_dataResponse !== 32'h0) begin
         errors++;
         $display("FAIL mtime_lo_carry: got %h required 00000000",
                  io_rsp_bits_dataResponse);
      end
      send(32'h4000_000C, 32'h0, 4'h0, 1'b0);
      checks++;
      if (io_rsp_bits_dataResponse !== 32'h1) begin
         errors++;
         $display("FAIL mtime_hi_carry: got %h required 00000001",
                  io_rsp_bits_dataResponse);
      end
      send(32'h4000_001C, 32'h0, 4'h0, 1'b0);
      checks++;
      if (io_rsp_bits_dataResponse !== 32'h1 || io_timer_irq !== 1'b1) begin
         errors++;
         $display("FAIL pend_set: status=%h irq=%b required status=1 irq=1",
                  io_rsp_bits_dataResponse, io_timer_irq);
      end
      // W1C while mtime >= cmp: set wins.
      send(32'h4000_001C, 32'h1, 4'h1, 1'b1);
      send(32'h4000_001C, 32'h0, 4'h0, 1'b0);
      checks++;
      if (io_rsp_bits_dataResponse !== 32'h1 || io_timer_irq !== 1'b1) begin
         errors++;
         $display("FAIL w1c_set_wins: status=%h irq=%b required status=1 irq=1",
                  io_rsp_bits_dataResponse, io_timer_irq);
      end
      send(32'h4000_0014, 32'hFFFF_FFFF, 4'hF, 1'b1);
      send(32'h4000_001C, 32'h1, 4'h1, 1'b1);
      checks++;
      if (io_timer_irq !== 1'b0) begin
         errors++;
         $display("FAIL w1c_clear_irq: got %b required 0", io_timer_irq);
      end
      send(32'h4000_001C, 32'h0, 4'h0, 1'b0);
      checks++;
      if (io_rsp_bits_dataResponse !== 32'h0) begin
         errors++;
         $display("FAIL w1c_clear_status: got %h required 00000000",
                  io_rsp_bits_dataResponse);
      end
      send(32'h4000_0018, 32'h0, 4'h0, 1'b0);
      checks++;
      if (io_rsp_bits_dataResponse !== 32'h3) begin
         errors++;
         $display("FAIL ctrl_read: got %h required 00000003",
                  io_rsp_bits_dataResponse);
      end
   endtask

   task automatic test_reset_mid;
      int late_valid;
      io_req_valid               = 1'b1;
      io_req_bits_addrRequest    = 32'h4000_0000;
      io_req_bits_isWrite        = 1'b0;
      io_req_bits_activeByteLane = 4'h0;
      @(posedge clock);
      #1;
      io_req_valid = 1'b0;
      checks++;
      if (io_rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_rsp: valid=%b required 1", io_rsp_valid);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (io_rsp_valid !== 1'b0 || io_rsp_bits_dataResponse !== 32'h0 ||
          io_gpio_out !== 32'h0 || io_timer_irq !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: valid=%b data=%h gpio=%h irq=%b required all 0",
                  io_rsp_valid, io_rsp_bits_dataResponse, io_gpio_out, io_timer_irq);
      end
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      late_valid = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         if (io_rsp_valid !== 1'b0) late_valid++;
      end
      checks++;
      if (late_valid != 0) begin
         errors++;
         $display("FAIL post_reset_rsp: %0d cycles with rsp_valid required 0",
                  late_valid);
      end
   endtask

   initial begin
      reset                      = 1'b1;
      io_req_valid               = 1'b0;
      io_req_bits_addrRequest    = 32'h0;
      io_req_bits_dataRequest    = 32'h0;
      io_req_bits_activeByteLane = 4'h0;
      io_req_bits_isWrite        = 1'b0;
      io_gpio_in                 = 32'h0;
      repeat (3) @(negedge clock);

      test_reset();
      test_cmp_reset();
      test_gpio_out();
      test_gpio_in();
      test_back_to_back();
      test_timer();
      test_reset_mid();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
